dma_burst_gen: RTL and testbench
================================

# dma_burst_gen

Burst generator for one DMA direction: accepts a transfer descriptor (start address, byte count, mode) and splits it into AXI4-legal burst requests for the AXI master interface stage directly downstream. Each burst carries one strobe mask for all of its beats. Unaligned head and tail bytes are therefore issued as single-beat bursts with narrowed strobes, and aligned middle bytes as full-strobe bursts. One instance serves the read streamer path and one serves the write streamer path.

## Interface
- `ADDR_WIDTH`, default 32: address and byte-count width.
- `DATA_WIDTH`, default 32: AXI data width. BYTES = DATA_WIDTH/8; BYTES must be a power of 2 and at most 128.
- `MAX_BEATS`, default 256: cap on INCR burst length; power of 2, ≤256.

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous and active-high.
- `dscpt_valid_i` in 1: descriptor valid.
- `dscpt_ready_o` out 1: descriptor accept.
- `dscpt_addr_i` in ADDR_WIDTH: byte start address.
- `dscpt_bytes_i` in ADDR_WIDTH: transfer length in bytes.
- `dscpt_mode_i` in 1: 0 = INCR, 1 = FIXED.
- `abort_i` in 1: stop after the current burst.
- `req_valid_o` out 1: burst request valid.
- `req_ready_i` in 1: burst accepted by the downstream stage.
- `req_addr_o` out ADDR_WIDTH: beat-aligned burst address.
- `req_alen_o` out 8: beats minus 1.
- `req_size_o` out 3: always log2(BYTES).
- `req_strb_o` out BYTES: strobe applied to every beat of the burst.
- `req_mode_o` out 1: copy of the descriptor mode.
- `done_o` out 1: one-cycle pulse at the end of a descriptor.
- `aborted_o` out 1: qualifies `done_o`; descriptor stopped early.
- `error_o` out 1: qualifies `done_o`; illegal FIXED descriptor.

## Operation
- The FSM has three states: IDLE, RUN and DONE. `dscpt_ready_o` = (state == IDLE).
- Descriptor handshake in IDLE:
  - Latch `cur_addr`, `bytes_left` and `mode`. Clear the abort-pending flag.
  - If `dscpt_bytes_i` == 0, go to DONE and issue no requests.
  - If FIXED and either the address is not beat-aligned or the byte count is not a multiple of BYTES, go to DONE with the error flag set and issue no requests.
  - Otherwise go to RUN.
- In RUN, `req_valid_o` = 1. Fields are computed combinationally from registers only, with `off` = `cur_addr` mod BYTES:
  - Partial beat: if `off` ≠ 0 or `bytes_left` < BYTES, then alen = 0 and n = min(BYTES − `off`, `bytes_left`). The strobe sets bits `off` .. `off`+n−1.
  - Full INCR burst: beats = min(`bytes_left`/BYTES, MAX_BEATS, (4096 − `cur_addr`[11:0])/BYTES). Strobe is all ones. n = beats·BYTES.
  - FIXED burst: beats = min(`bytes_left`/BYTES, 16). Strobe is all ones.
  - `req_addr_o` = `cur_addr` with its low log2(BYTES) bits cleared.
- On request handshake:
  - `bytes_left` −= n.
  - INCR: `cur_addr` += n, modulo 2^ADDR_WIDTH (wraps to 0). FIXED: `cur_addr` is unchanged.
  - If `bytes_left` becomes 0 or abort is pending, go to DONE.
- Abort:
  - `abort_i` high in RUN sets the abort-pending flag.
  - The burst currently presented stays valid and stable until it is accepted. Then the FSM goes to DONE with `aborted_o` = 1.
  - `abort_i` is ignored in IDLE and DONE.
- DONE lasts one cycle:
  - `done_o` = 1, with `aborted_o` and `error_o` valid.
  - Next state is IDLE.
  - Error and abort never coincide.

## Timing
- Reset value of every output is 0, except `dscpt_ready_o` = 1 (IDLE). Registers: state = IDLE, all flags cleared.
- Reset asserted mid-RUN drops the request immediately, with no completion pulse.
- Descriptor accepted at cycle T → `req_valid_o` at T+1.
- Zero-length or error descriptor: `done_o` at T+1, `dscpt_ready_o` at T+2.
- Handshake of the non-final burst at cycle k → the next burst is presented at k+1 with `req_valid_o` held high continuously (back-to-back).
- Final handshake at cycle N → `done_o` at N+1, `dscpt_ready_o` at N+2.
- `req_valid_o` never drops without a handshake. All `req_*` fields are stable while valid and not ready.
- There is no combinational path from any input to the `req_*` outputs.

## Test plan
Parameters for all scenarios: DATA_WIDTH = 32 (BYTES = 4), MAX_BEATS = 256.

1. INCR 0x1000, 64 bytes, ready tied high → one request: addr 0x1000, alen 15, strb 0xF, size 2. `done_o` follows 1 cycle after the handshake, with `aborted_o` = `error_o` = 0.
2. INCR 0x1003, 10 bytes → three requests in order:
   - 0x1000, alen 0, strb 0x8.
   - 0x1004, alen 1, strb 0xF.
   - 0x100C, alen 0, strb 0x1.
3. 4 KB and length caps:
   - INCR 0x0FF0, 32 bytes → 0x0FF0 alen 3, then 0x1000 alen 3.
   - INCR 0x0, 2048 bytes → 0x0 alen 255, then 0x400 alen 255.
4. FIXED cases:
   - FIXED 0x2000, 80 bytes → 0x2000 alen 15, then 0x2000 alen 3.
   - FIXED 0x2002, 8 bytes → no request; `done_o` with `error_o` = 1 at T+1.
5. Stall and abort: INCR 0x0, 4096 bytes, `req_ready_i` low for 5 cycles, `abort_i` pulsed during the stall → request 0x0 alen 255 held stable for all 5 cycles. After its handshake: no further requests, `done_o` with `aborted_o` = 1.
6. Boundary and reset cases:
   - Zero-length descriptor → `done_o` at T+1 with no request.
   - INCR 0xFFFFFFFC, 8 bytes → 0xFFFFFFFC alen 0, then 0x0 alen 0 (wrap).
   - `rst` asserted mid-RUN → `req_valid_o` drops immediately; `dscpt_ready_o` = 1 after release.

Source files
------------

// File: rtl/dma_burst_gen.sv
// dma_burst_gen: splits one DMA transfer descriptor into AXI4-legal burst
// requests. Unaligned head/tail bytes become single-beat bursts with narrowed
// strobes; aligned middle bytes become full-strobe bursts capped by MAX_BEATS
// (INCR), 16 beats (FIXED) and the 4 KB page boundary (INCR).
module dma_burst_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BEATS  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dscpt_valid_i,
  output logic                    dscpt_ready_o,
  input  logic [ADDR_WIDTH-1:0]   dscpt_addr_i,
  input  logic [ADDR_WIDTH-1:0]   dscpt_bytes_i,
  input  logic                    dscpt_mode_i,
  input  logic                    abort_i,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [ADDR_WIDTH-1:0]   req_addr_o,
  output logic [7:0]              req_alen_o,
  output logic [2:0]              req_size_o,
  output logic [DATA_WIDTH/8-1:0] req_strb_o,
  output logic                    req_mode_o,
  output logic                    done_o,
  output logic                    aborted_o,
  output logic                    error_o
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LOG2B = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] BYTES_A   = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_B_A   = ADDR_WIDTH'(MAX_BEATS);
  localparam logic [ADDR_WIDTH-1:0] FIX_MAX_A = ADDR_WIDTH'(16);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] bytes_left;
  logic                  mode;
  logic                  abort_pend;
  logic                  abort_flag;
  logic                  error_flag;

  logic [ADDR_WIDTH-1:0] off;
  logic                  partial;
  logic [ADDR_WIDTH-1:0] head_room;
  logic [ADDR_WIDTH-1:0] page_beats;
  logic [12:0]           page_bytes;
  logic [ADDR_WIDTH-1:0] beats;
  logic [ADDR_WIDTH-1:0] n_bytes;
  logic [ADDR_WIDTH-1:0] left_nxt;
  logic [7:0]            alen;
  logic [BYTES-1:0]      strb;
  logic                  desc_zero;
  logic                  desc_err;
  logic                  abort_eff;
  logic                  run;

  // Burst sizing from registered state only (no input-to-request path).
  always_comb begin
    off        = cur_addr & OFF_MASK;
    partial    = (off != '0) || (bytes_left < BYTES_A);
    head_room  = BYTES_A - off;
    page_bytes = 13'd4096 - {1'b0, cur_addr[11:0]};
    page_beats = ADDR_WIDTH'(page_bytes >> LOG2B);
    beats      = bytes_left >> LOG2B;
    if (mode) begin
      if (beats > FIX_MAX_A) beats = FIX_MAX_A;
    end else begin
      if (beats > MAX_B_A)    beats = MAX_B_A;
      if (beats > page_beats) beats = page_beats;
    end
    if (partial) begin
      n_bytes = (head_room < bytes_left) ? head_room : bytes_left;
      alen    = '0;
    end else begin
      n_bytes = beats << LOG2B;
      alen    = 8'(beats - 1'b1);
    end
    for (int unsigned i = 0; i < BYTES; i++) begin
      strb[i] = partial ? ((ADDR_WIDTH'(i) >= off) && (ADDR_WIDTH'(i) < off + n_bytes)) : 1'b1;
    end
    left_nxt = bytes_left - n_bytes;
  end

  // Descriptor classification at the handshake.
  always_comb begin
    desc_zero = (dscpt_bytes_i == '0);
    desc_err  = dscpt_mode_i &&
                (((dscpt_addr_i & OFF_MASK) != '0) || ((dscpt_bytes_i & OFF_MASK) != '0));
    abort_eff = abort_pend || abort_i;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state and outputs.
  always_comb begin
    state_nxt     = state;
    run           = (state == S_RUN);
    dscpt_ready_o = (state == S_IDLE);
    req_valid_o   = run;
    req_addr_o    = run ? (cur_addr & ~OFF_MASK) : '0;
    req_alen_o    = run ? alen : '0;
    req_size_o    = run ? 3'(LOG2B) : '0;
    req_strb_o    = run ? strb : '0;
    req_mode_o    = run ? mode : 1'b0;
    done_o        = (state == S_DONE);
    aborted_o     = (state == S_DONE) && abort_flag;
    error_o       = (state == S_DONE) && error_flag;
    unique case (state)
      S_IDLE: if (dscpt_valid_i) state_nxt = (desc_zero || desc_err) ? S_DONE : S_RUN;
      S_RUN:  if (req_ready_i && ((left_nxt == '0) || abort_eff)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Descriptor registers, progress tracking and completion flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      bytes_left <= '0;
      mode       <= 1'b0;
      abort_pend <= 1'b0;
      abort_flag <= 1'b0;
      error_flag <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (dscpt_valid_i) begin
          cur_addr   <= dscpt_addr_i;
          bytes_left <= dscpt_bytes_i;
          mode       <= dscpt_mode_i;
          abort_pend <= 1'b0;
          abort_flag <= 1'b0;
          error_flag <= !desc_zero && desc_err;
        end
        S_RUN: begin
          if (abort_i) abort_pend <= 1'b1;
          if (req_ready_i) begin
            bytes_left <= left_nxt;
            if (!mode) cur_addr <= cur_addr + n_bytes;
            // An abort landing on the final burst leaves nothing cut short.
            abort_flag <= abort_eff && (left_nxt != '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_burst_gen.sv
// Self-checking bench for dma_burst_gen (DATA_WIDTH=32, MAX_BEATS=256).
module tb_dma_burst_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        dscpt_valid_i;
  logic        dscpt_ready_o;
  logic [31:0] dscpt_addr_i;
  logic [31:0] dscpt_bytes_i;
  logic        dscpt_mode_i;
  logic        abort_i;
  logic        req_valid_o;
  logic        req_ready_i;
  logic [31:0] req_addr_o;
  logic [7:0]  req_alen_o;
  logic [2:0]  req_size_o;
  logic [3:0]  req_strb_o;
  logic        req_mode_o;
  logic        done_o;
  logic        aborted_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [3:0]  strb;
  } burst_t;

  burst_t exp_q[$];

  dma_burst_gen #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BEATS(256)) dut (
    .clk(clk), .rst(rst),
    .dscpt_valid_i(dscpt_valid_i), .dscpt_ready_o(dscpt_ready_o),
    .dscpt_addr_i(dscpt_addr_i), .dscpt_bytes_i(dscpt_bytes_i),
    .dscpt_mode_i(dscpt_mode_i), .abort_i(abort_i),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_alen_o(req_alen_o), .req_size_o(req_size_o),
    .req_strb_o(req_strb_o), .req_mode_o(req_mode_o),
    .done_o(done_o), .aborted_o(aborted_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: walk the byte range, emitting head/tail single beats and
  // capped full bursts, purely from the transfer rules.
  function automatic bit build(input logic [31:0] a, input logic [31:0] n, input bit fx);
    logic [31:0] addr;
    longint      left, off, take, beats, room;
    burst_t      b;
    exp_q.delete();
    if (n == 0) return 1'b0;
    if (fx && ((a % 4) != 0 || (n % 4) != 0)) return 1'b1;
    addr = a;
    left = n;
    while (left > 0) begin
      off = addr % 4;
      if (off != 0 || left < 4) begin
        take   = (4 - off < left) ? 4 - off : left;
        b.alen = 8'd0;
        b.strb = 4'(((1 << take) - 1) << off);
      end else begin
        beats = left / 4;
        if (fx) begin
          if (beats > 16) beats = 16;
        end else begin
          room = (4096 - (addr % 4096)) / 4;
          if (beats > 256)  beats = 256;
          if (beats > room) beats = room;
        end
        take   = beats * 4;
        b.alen = 8'(beats - 1);
        b.strb = 4'hF;
      end
      b.addr = addr & 32'hFFFF_FFFC;
      exp_q.push_back(b);
      left -= take;
      if (!fx) addr = addr + 32'(take);
    end
    return 1'b0;
  endfunction

  // Entered at posedge+1 with the DUT idle. rmode: 0 ready high, 1 random,
  // 2 low for the first 5 cycles. abort_at: cycle index to pulse abort_i.
  task automatic run_desc(input string tag, input logic [31:0] a, input logic [31:0] n,
                          input bit fx, input int rmode, input int abort_at);
    bit     err, done_next, abort_seen, aborted_exp, finished;
    burst_t f;
    err = build(a, n, fx);
    @(negedge clk);
    check({tag, ".idle_ready"}, dscpt_ready_o, 1);
    @(posedge clk); #1;
    dscpt_valid_i = 1'b1;
    dscpt_addr_i  = a;
    dscpt_bytes_i = n;
    dscpt_mode_i  = fx;
    @(posedge clk); #1;
    dscpt_valid_i = 1'b0;
    dscpt_addr_i  = $urandom;
    dscpt_bytes_i = $urandom;
    done_next   = (exp_q.size() == 0);
    abort_seen  = 1'b0;
    aborted_exp = 1'b0;
    finished    = 1'b0;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      case (rmode)
        0:       req_ready_i = 1'b1;
        1:       req_ready_i = 1'($urandom_range(0, 1));
        default: req_ready_i = (cyc >= 5);
      endcase
      abort_i = (cyc == abort_at);
      @(negedge clk);
      if (done_next) begin
        check({tag, ".done"},    done_o,      1);
        check({tag, ".valid0"},  req_valid_o, 0);
        check({tag, ".aborted"}, aborted_o,   aborted_exp);
        check({tag, ".error"},   error_o,     err);
        finished = 1'b1;
      end else begin
        f = exp_q[0];
        check({tag, ".valid"}, req_valid_o, 1);
        check({tag, ".nodone"}, done_o, 0);
        check({tag, ".addr"},  req_addr_o, f.addr);
        check({tag, ".alen"},  req_alen_o, f.alen);
        check({tag, ".strb"},  req_strb_o, f.strb);
        check({tag, ".size"},  req_size_o, 2);
        check({tag, ".mode"},  req_mode_o, fx);
        if (abort_i) abort_seen = 1'b1;
        if (req_ready_i) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) done_next = 1'b1;
          else if (abort_seen) begin
            aborted_exp = 1'b1;
            done_next   = 1'b1;
          end
        end
      end
      @(posedge clk); #1;
    end
    req_ready_i = 1'b0;
    abort_i     = 1'b0;
    if (!finished) check({tag, ".timeout"}, 0, 1);
    @(negedge clk);
    check({tag, ".ready_after"}, dscpt_ready_o, 1);
    check({tag, ".done_1cyc"},   done_o,        0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] ra, rn;
    bit          rf;
    rst = 1'b1;
    dscpt_valid_i = 1'b0; dscpt_addr_i = '0; dscpt_bytes_i = '0; dscpt_mode_i = 1'b0;
    abort_i = 1'b0; req_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.ready",   dscpt_ready_o, 1);
    check("rst.valid",   req_valid_o,   0);
    check("rst.done",    done_o,        0);
    check("rst.aborted", aborted_o,     0);
    check("rst.error",   error_o,       0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_desc("incr64",   32'h0000_1000, 64,   1'b0, 0, -1);
    run_desc("unalign",  32'h0000_1003, 10,   1'b0, 0, -1);
    run_desc("page4k",   32'h0000_0FF0, 32,   1'b0, 0, -1);
    run_desc("maxbeats", 32'h0000_0000, 2048, 1'b0, 0, -1);
    run_desc("fixed80",  32'h0000_2000, 80,   1'b1, 0, -1);
    run_desc("fixederr", 32'h0000_2002, 8,    1'b1, 0, -1);
    run_desc("abort",    32'h0000_0000, 4096, 1'b0, 2, 2);
    run_desc("zero",     32'h0000_1234, 0,    1'b0, 0, -1);
    run_desc("wrap",     32'hFFFF_FFFC, 8,    1'b0, 0, -1);

    for (int k = 0; k < 10; k++) begin
      rf = 1'($urandom_range(0, 1));
      ra = $urandom;
      if (rf) begin
        if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
        rn = 32'($urandom_range(1, 50)) * 4;
        if ($urandom_range(0, 5) == 0) rn = rn + 1;
      end else begin
        if ($urandom_range(0, 1) != 0) ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
        rn = 32'($urandom_range(1, 600));
      end
      run_desc("rand", ra, rn, rf, 1, -1);
    end

    // Reset asserted while a burst is outstanding.
    @(posedge clk); #1;
    dscpt_valid_i = 1'b1; dscpt_addr_i = 32'h0; dscpt_bytes_i = 32'd4096; dscpt_mode_i = 1'b0;
    req_ready_i = 1'b0;
    @(posedge clk); #1;
    dscpt_valid_i = 1'b0;
    @(negedge clk);
    check("midrst.valid_before", req_valid_o, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst.valid_drop", req_valid_o, 0);
    check("midrst.no_done",    done_o,      0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst.ready", dscpt_ready_o, 1);
    check("midrst.idle",  req_valid_o,   0);
    check("midrst.done",  done_o,        0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
